// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline definitions for the register scoreboard and the ID/EXE stage.
package reg_scoreboard_pkg;

  localparam int REG_IDX_W = 4;
  localparam int NUM_REGS  = 16;
  localparam int CNT_W     = 2;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] dest;
    logic                 wb_en;
    logic                 mem_r_en;
  } issue_rec_t;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// One register's saturating up/down in-flight writer counter.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q, count_d;

  // inc and dec together cancel; a saturated or empty counter holds and flags err
  always_comb begin
    count_d = count_q;
    err     = 1'b0;
    if (inc && !dec) begin
      if (count_q == CNT_MAX) err = 1'b1;
      else                    count_d = count_q + 1'b1;
    end else if (dec && !inc) begin
      if (count_q == '0) err = 1'b1;
      else               count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes and answers the ID-stage hazard query.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = reg_scoreboard_pkg::NUM_REGS,
  parameter int CNT_W    = reg_scoreboard_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_dest,
  input  logic                 issue_wb_en,
  input  logic                 issue_mem_r_en,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_dest,
  input  logic [REG_IDX_W-1:0] src1,
  input  logic [REG_IDX_W-1:0] src2,
  input  logic                 two_src,
  input  logic                 FW_EN,
  output logic                 hazard_detected,
  output logic [NUM_REGS-1:0]  pending,
  output logic                 sb_error
);

  logic [NUM_REGS-1:0]            inc, dec, zero, err;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;

  issue_rec_t           issue_rec;
  logic                 load_valid_q, load_valid_d;
  logic [REG_IDX_W-1:0] load_dest_q, load_dest_d;
  logic                 sb_error_q, sb_error_d;

  assign issue_rec = '{valid: issue_valid, dest: issue_dest,
                       wb_en: issue_wb_en, mem_r_en: issue_mem_r_en};

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
    assign inc[i] = issue_rec.valid & issue_rec.wb_en & (issue_rec.dest == REG_IDX_W'(i));
    assign dec[i] = wb_en & (wb_dest == REG_IDX_W'(i));

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc[i]),
      .dec   (dec[i]),
      .count (cnt[i]),
      .zero  (zero[i]),
      .err   (err[i])
    );
  end

  // Load sitting in EXE for exactly one cycle; a bubble closes the window
  always_comb begin
    load_valid_d = issue_rec.valid & issue_rec.wb_en & issue_rec.mem_r_en;
    load_dest_d  = issue_rec.dest;
    sb_error_d   = sb_error_q | (|err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_valid_q <= 1'b0;
      load_dest_q  <= '0;
      sb_error_q   <= 1'b0;
    end else begin
      load_valid_q <= load_valid_d;
      load_dest_q  <= load_dest_d;
      sb_error_q   <= sb_error_d;
    end
  end

  // A writer in WB this cycle does not count: the regfile writes on the falling edge
  logic eff1, eff2, match1, match2, ld1, ld2;
  always_comb begin
    eff1   = cnt[src1] != {{(CNT_W-1){1'b0}}, (wb_en && wb_dest == src1)};
    eff2   = cnt[src2] != {{(CNT_W-1){1'b0}}, (wb_en && wb_dest == src2)};
    match1 = eff1;
    match2 = two_src & eff2;
    ld1    = load_valid_q & (src1 == load_dest_q);
    ld2    = two_src & load_valid_q & (src2 == load_dest_q);
    hazard_detected = FW_EN ? (ld1 | ld2) : (match1 | match2);
  end

  assign pending  = ~zero;
  assign sb_error = sb_error_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed + randomized bench for reg_scoreboard against a per-register count model.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_wb_en, issue_mem_r_en, wb_en, two_src, FW_EN;
  logic [3:0] issue_dest, wb_dest, src1, src2;
  logic       hazard_detected, sb_error;
  logic [15:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int cnt_m [16];
  bit err_m;
  bit ld_v_m;
  int ld_d_m;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_wb_en(issue_wb_en),
    .issue_mem_r_en(issue_mem_r_en), .wb_en(wb_en), .wb_dest(wb_dest),
    .src1(src1), .src2(src2), .two_src(two_src), .FW_EN(FW_EN),
    .hazard_detected(hazard_detected), .pending(pending), .sb_error(sb_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_haz();
    int e1, e2;
    e1 = cnt_m[src1] - ((wb_en && wb_dest == src1) ? 1 : 0);
    e2 = cnt_m[src2] - ((wb_en && wb_dest == src2) ? 1 : 0);
    if (!FW_EN) return (e1 != 0) || (two_src && e2 != 0);
    return ld_v_m && ((src1 == ld_d_m) || (two_src && src2 == ld_d_m));
  endfunction

  function automatic logic [15:0] m_pend();
    logic [15:0] p;
    for (int r = 0; r < 16; r++) p[r] = (cnt_m[r] != 0);
    return p;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 16; r++) cnt_m[r] = 0;
    err_m = 0; ld_v_m = 0; ld_d_m = 0;
  endtask

  task automatic m_update();
    bit up, dn;
    up = issue_valid && issue_wb_en;
    dn = wb_en;
    if (up && dn && issue_dest == wb_dest) begin
      // same register both ways: net zero
    end else begin
      if (up) begin
        if (cnt_m[issue_dest] == 3) err_m = 1;
        else cnt_m[issue_dest]++;
      end
      if (dn) begin
        if (cnt_m[wb_dest] == 0) err_m = 1;
        else cnt_m[wb_dest]--;
      end
    end
    ld_v_m = issue_valid && issue_wb_en && issue_mem_r_en;
    ld_d_m = issue_dest;
  endtask

  task automatic drive(input bit iv, input int id, input bit iw, input bit im,
                       input bit we, input int wd, input int s1, input int s2,
                       input bit ts, input bit fw);
    issue_valid = iv; issue_dest = 4'(id); issue_wb_en = iw; issue_mem_r_en = im;
    wb_en = we; wb_dest = 4'(wd); src1 = 4'(s1); src2 = 4'(s2); two_src = ts; FW_EN = fw;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // called just after a rising edge; checks the query mid-cycle, then the registered state
  task automatic cyc(input string tag);
    @(negedge clk);
    check({tag, ".hazard"}, hazard_detected, m_haz());
    @(posedge clk);
    m_update();
    #1;
    check({tag, ".pending"}, pending, m_pend());
    check({tag, ".sb_error"}, sb_error, err_m);
  endtask

  task automatic do_reset(input string tag);
    drive(0, 0, 0, 0, 0, 0, 3, 3, 1, 0);
    rst = 1'b1;
    #1;
    m_reset();
    check({tag, ".rst_pending"}, pending, 16'h0);
    check({tag, ".rst_hazard"}, hazard_detected, 1'b0);
    check({tag, ".rst_err"}, sb_error, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    m_update();
    #1;
  endtask

  initial begin
    bit iv, found;
    int wd, off;
    idle();
    rst = 1'b1;
    m_reset();
    #12;
    check("reset.pending", pending, 16'h0);
    check("reset.hazard", hazard_detected, 1'b0);
    check("reset.sb_error", sb_error, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); m_update(); #1;

    // reset mid-flight after issuing R3
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); cyc("midrst_issue");
    check("midrst.pend3", pending[3], 1'b1);
    do_reset("midrst");
    drive(0, 0, 0, 0, 0, 0, 3, 0, 0, 0); cyc("midrst_after");
    check("midrst.haz_after", hazard_detected, 1'b0);

    // no-forward RAW on R2
    drive(1, 2, 1, 0, 0, 0, 2, 0, 0, 0); cyc("raw_c0");
    drive(0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    @(negedge clk); check("raw_c1.hazard", hazard_detected, 1'b1);
    @(posedge clk); m_update(); #1;
    cyc("raw_c2");
    drive(0, 0, 0, 0, 1, 2, 2, 0, 0, 0);
    @(negedge clk); check("raw_c3.hazard_bypass", hazard_detected, 1'b0);
    check("raw_c3.pend2_before", pending[2], 1'b1);
    @(posedge clk); m_update(); #1;
    check("raw_c3.pend2_after", pending[2], 1'b0);

    // load-use with forwarding, two sources
    drive(1, 5, 1, 1, 0, 0, 0, 0, 0, 1); cyc("ldu_c0");
    drive(0, 0, 0, 0, 0, 0, 0, 5, 1, 1);
    @(negedge clk); check("ldu_c1.hazard", hazard_detected, 1'b1);
    @(posedge clk); m_update(); #1;
    cyc("ldu_c2");
    check("ldu_c2.hazard", hazard_detected, 1'b0);
    // same with src2 not a real operand
    drive(1, 5, 1, 1, 0, 0, 0, 0, 0, 1); cyc("ldu1_c0");
    drive(0, 0, 0, 0, 0, 0, 0, 5, 0, 1);
    @(negedge clk); check("ldu1_c1.hazard", hazard_detected, 1'b0);
    @(posedge clk); m_update(); #1;
    cyc("ldu1_c2");
    do_reset("ldu_clr");

    // simultaneous inc/dec on R7
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0); cyc("sim_c0");
    drive(1, 7, 1, 0, 1, 7, 0, 0, 0, 0); cyc("sim_c1");
    check("sim.pend7", pending[7], 1'b1);
    check("sim.err", sb_error, 1'b0);

    // non-writing instruction to R4
    drive(1, 4, 0, 0, 0, 0, 4, 0, 0, 0); cyc("cmp_c0");
    drive(0, 0, 0, 0, 0, 0, 4, 0, 0, 0); cyc("cmp_c1");
    check("cmp.pend4", pending[4], 1'b0);
    check("cmp.haz", hazard_detected, 1'b0);

    // overflow on R1
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); cyc("ovf");
    end
    check("ovf.err", sb_error, 1'b1);
    do_reset("ovf_clr");

    // underflow on R9
    drive(0, 0, 0, 0, 1, 9, 9, 0, 0, 0); cyc("udf");
    check("udf.err", sb_error, 1'b1);
    check("udf.pend9", pending[9], 1'b0);
    do_reset("udf_clr");

    // randomized traffic, respecting the bubble contract
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset("rnd_rst");
        continue;
      end
      wd = $urandom_range(0, 15);
      found = 0;
      if ($urandom_range(0, 3) != 0) begin
        off = $urandom_range(0, 15);
        for (int r = 0; r < 16; r++)
          if (!found && cnt_m[(r + off) % 16] != 0) begin
            wd = (r + off) % 16; found = 1;
          end
      end
      drive(0, $urandom_range(0, 15), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            found || ($urandom_range(0, 7) == 0), wd,
            $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
            $urandom_range(0, 1));
      iv = $urandom_range(0, 3) != 0;
      issue_valid = iv && !m_haz();
      cyc("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Sequential replacement for the stage-compare hazard check in the ARM 5-stage pipeline.
- Tracks in-flight register writes. Set on the issue side (ID->EXE transfer), cleared on the writeback side (WB stage).
- Answers the ID-stage source-operand query with hazard_detected.
- Sits beside the register file; drives the IF/ID freeze and the ID/EXE bubble insertion.

Parameters:
- NUM_REGS, 16, architectural registers tracked (R0-R15); the index width is 4 bits.
- CNT_W, 2, width of the per-register pending counter. Maximum legal in-flight writers to one register is 3 (EXE, MEM, WB).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- issue_valid  in  1  an instruction moves ID->EXE this cycle (ID/EXE not frozen, no bubble)
- issue_dest  in  4  destination of the issuing instruction
- issue_wb_en  in  1  issuing instruction writes issue_dest
- issue_mem_r_en  in  1  issuing instruction is a load
- wb_en  in  1  WB stage writes the register file this cycle
- wb_dest  in  4  WB destination
- src1  in  4  ID-stage first source
- src2  in  4  ID-stage second source
- two_src  in  1  src2 is a real operand
- FW_EN  in  1  forwarding unit enabled
- hazard_detected  out  1  combinational; stall ID this cycle
- pending  out  16  registered; bit i = count[i] != 0
- sb_error  out  1  registered, sticky; counter overflow or underflow seen

Behaviour:
- Reset:
  - All counters = 0; load_exe_valid = 0; load_exe_dest = 0; sb_error = 0.
  - Hence pending = 0 and hazard_detected = 0.
  - Reset asserted mid-operation discards all in-flight tracking immediately (asynchronous).
- Issue (inc):
  - Condition: issue_valid & issue_wb_en.
  - count[issue_dest] increments on the next edge.
- Writeback (dec):
  - Condition: wb_en.
  - count[wb_dest] decrements on the next edge.
- Same register incremented and decremented in one cycle: count unchanged, no error.
- Different registers in one cycle: both updates apply.
- Overflow: increment at count == 2^CNT_W-1 -> counter holds, sb_error sets.
- Underflow: decrement at count == 0 -> counter holds at 0, sb_error sets.
- sb_error clears only on rst.
- Load tracker (1-cycle window, the load sitting in EXE):
  - Every edge: load_exe_valid <= issue_valid & issue_wb_en & issue_mem_r_en; load_exe_dest <= issue_dest.
  - When issue_valid = 0, load_exe_valid <= 0. A bubble clears the window.
- Effective pending for query register r:
  - eff(r) = (count[r] - (wb_en & wb_dest==r)) != 0.
  - Rationale: the register file writes on the falling edge, so a producer in WB never stalls.
- match1 = eff(src1). match2 = two_src & eff(src2).
- ld1 = load_exe_valid & (src1 == load_exe_dest). ld2 = two_src & load_exe_valid & (src2 == load_exe_dest).
- hazard_detected:
  - FW_EN = 0: match1 | match2.
  - FW_EN = 1: ld1 | ld2 (load-use only; everything else is forwarded).
  - Purely combinational from current state and inputs; zero latency.
- Upstream contract: issue_valid must be 0 in any cycle where hazard_detected = 1 (the bubble). The block does not gate it internally.
- Writes to R15 are tracked like any other register. No special case.

Decomposition:
- Shared pipeline package holds:
  - REG_IDX_W = 4, NUM_REGS = 16.
  - The issue-record typedef {valid, dest, wb_en, mem_r_en}, reused by ID/EXE.
- One natural sub-module: sb_counter. Holds one register's saturating up/down counter, with inc, dec, zero and err outputs; instantiated NUM_REGS times.
- Query and compare logic stays in the top level.

Test Plan:
- Reset mid-flight: issue R3 (count 1), assert rst between edges -> pending = 0 and hazard_detected = 0 immediately. After release, query src1 = 3 -> 0.
- No-forward RAW:
  - FW_EN = 0; issue ADD R2 at cycle 0; query src1 = 2 on cycles 1-3.
  - hazard_detected = 1 on cycles 1-2. On cycle 3 (wb_en, wb_dest = 2) it is 0 via the WB bypass.
  - pending[2] falls after the cycle-3 edge.
- Load-use with forwarding:
  - FW_EN = 1; issue LDR R5 at cycle 0; cycle 1 query src2 = 5, two_src = 1 -> hazard_detected = 1.
  - Cycle 1 issue_valid = 0, so cycle 2 -> 0.
  - Repeat with two_src = 0 -> 0 both cycles.
- Simultaneous inc/dec on one register: count[7] = 1; same cycle issue R7 and wb R7 -> count[7] stays 1, sb_error = 0.
- Saturation and error:
  - Four issues to R1 with no writeback -> count[1] = 3, sb_error = 1 after the 4th edge.
  - Separately, wb R9 with count 0 -> sb_error = 1 and count[9] stays 0.
- Non-writing instructions: issue CMP with issue_wb_en = 0 and dest = 4 -> pending[4] stays 0, no hazard on src1 = 4.
